ray_core_dispatcher: RTL

- Synthesizable pixel scheduler and initiator on the ray-core strobe/state handshake.
- Walks the framebuffer in raster order and issues one pixel at a time to a single RayCore through its strobe, x, y and frame_start inputs.
- Waits for the core to report RCS_Done before issuing the next pixel.
- At frame end, waits for a vertical-blanking window before starting the next frame, and toggles the frame-flip bit for the FrameBufferWriter.

---
 rtl/ray_core_dispatcher.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ray_core_dispatcher.sv
// ray_core_dispatcher: walks the framebuffer in raster order and issues one
// pixel at a time to a single RayCore over the strobe/state handshake, then
// waits for a fresh vertical-blanking window before starting the next frame.
// Optional per-pixel watchdog: define RAYCORE_WATCHDOG_EN.
package ray_core_pkg;
    typedef enum logic [2:0] {
        RCS_Init,
        RCS_SetupRay,
        RCS_Trace,
        RCS_Shade,
        RCS_Done
    } RayCoreState;
endpackage

module ray_core_dispatcher
    import ray_core_pkg::*;
#(
    parameter int FB_WIDTH        = 320,
    parameter int FB_HEIGHT       = 240,
    parameter int COORD_W         = 11,
    parameter int WATCHDOG_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               render_en,
    input  logic               vsync,
    input  RayCoreState        core_state,
    output logic               strobe,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start,
    output logic               frame_flip,
    output logic               frame_done,
    output logic               busy,
    output logic               timeout,
    output logic [15:0]        timeout_count
);
    typedef enum logic [1:0] {S_INIT, S_ACK, S_WAIT, S_VSYNC} DispState;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FB_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FB_HEIGHT - 1);

    DispState           state, stateNext;
    logic               armed, armedNext;
    logic [COORD_W-1:0] xNext, yNext;
    logic               strobeNext, frameStartNext, frameDoneNext, flipNext;
    logic               pixelDone;  // current pixel finished (core Done or watchdog skip)
    logic               wdHit;
    logic               coreIdle;

    // Init/Done are the only states in which the core can take a new pixel
    assign coreIdle = (core_state == RCS_Init) || (core_state == RCS_Done);

`ifdef RAYCORE_WATCHDOG_EN
    logic [15:0] wdCnt;

    // Fires on the cycle the counter would step onto the limit, so the skip
    // strobe lands exactly WATCHDOG_CYCLES cycles after the stuck strobe.
    assign wdHit = ((state == S_ACK) || (state == S_WAIT)) &&
                   (wdCnt == 16'(WATCHDOG_CYCLES - 1));

    // Per-pixel cycle counter, skip pulse and saturating skip tally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdCnt         <= '0;
            timeout       <= 1'b0;
            timeout_count <= '0;
        end else begin
            timeout <= wdHit;
            if (wdHit && (timeout_count != 16'hFFFF))
                timeout_count <= timeout_count + 16'd1;
            if (strobeNext)
                wdCnt <= '0;
            else if ((state == S_ACK) || (state == S_WAIT))
                wdCnt <= wdCnt + 16'd1;
        end
    end
`else
    // No watchdog: the limit has no effect and the dispatcher waits forever
    assign wdHit         = 1'b0;
    assign timeout       = 1'b0;
    assign timeout_count = 16'(WATCHDOG_CYCLES) & 16'h0000;
`endif

    // Next-state and next-output decode
    always_comb begin
        stateNext      = state;
        armedNext      = armed;
        xNext          = x;
        yNext          = y;
        strobeNext     = 1'b0;
        frameStartNext = 1'b0;
        frameDoneNext  = 1'b0;
        flipNext       = frame_flip;
        pixelDone      = 1'b0;
        case (state)
            S_INIT: begin
                if (render_en && (core_state == RCS_Init)) begin
                    xNext          = '0;
                    yNext          = '0;
                    strobeNext     = 1'b1;
                    frameStartNext = 1'b1;
                    stateNext      = S_ACK;
                end
            end
            S_ACK: begin
                // A Done still visible here belongs to the previous pixel
                if (wdHit)
                    pixelDone = 1'b1;
                else if (!coreIdle)
                    stateNext = S_WAIT;
            end
            S_WAIT: begin
                pixelDone = (core_state == RCS_Done) || wdHit;
            end
            S_VSYNC: begin
                // Arm on the high phase so a frame starts only on a fresh low
                if (vsync)
                    armedNext = 1'b1;
                if (armed && !vsync && render_en && coreIdle) begin
                    armedNext      = 1'b0;
                    flipNext       = ~frame_flip;
                    xNext          = '0;
                    yNext          = '0;
                    strobeNext     = 1'b1;
                    frameStartNext = 1'b1;
                    stateNext      = S_ACK;
                end
            end
            default: stateNext = S_INIT;
        endcase

        if (pixelDone) begin
            if ((x == X_LAST) && (y == Y_LAST)) begin
                frameDoneNext = 1'b1;
                armedNext     = 1'b0;
                stateNext     = S_VSYNC;
            end else begin
                if (x == X_LAST) begin
                    xNext = '0;
                    yNext = y + 1'b1;
                end else begin
                    xNext = x + 1'b1;
                end
                strobeNext = 1'b1;
                stateNext  = S_ACK;
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_INIT;
            armed       <= 1'b0;
            strobe      <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            frame_flip  <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= stateNext;
            armed       <= armedNext;
            strobe      <= strobeNext;
            x           <= xNext;
            y           <= yNext;
            frame_start <= frameStartNext;
            frame_flip  <= flipNext;
            frame_done  <= frameDoneNext;
            busy        <= (stateNext == S_ACK) || (stateNext == S_WAIT);
        end
    end
endmodule
